// File: rtl/inst_mem_loader_if.sv
// -----------------------------------------------------------------------------
// inst_mem_loader_if
//
// Bundles the two buses around the program loader:
//   - byte stream : in_valid / in_byte from the source, in_ready back to it
//   - memory write: mem_we / mem_addr / mem_wdata into the instruction memory
//
// Modports:
//   master - the environment side (byte source plus memory observer)
//   slave  - the loader itself
//
// Parameter:
//   ADDR_WIDTH - word-address width of the instruction memory
// -----------------------------------------------------------------------------
interface inst_mem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic [7:0]            in_byte;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Writes a program image, received as a byte stream, into instruction memory
// while holding the CPU in reset. The CPU reset is released only once a
// complete, well-formed image has been written.
//
// Stream: LEN_HI, LEN_LO (big-endian word count N), then N 32-bit words,
// most-significant byte first.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   start    - one-cycle pulse; begins a load from IDLE, DONE or ERR
//   bus      - slave side of inst_mem_loader_if (byte stream in, memory write out)
//   cpu_rst  - active-high reset to the CPU
//   done     - image loaded (level, held until the next start)
//   err      - load aborted (level, held until the next start)
//
// Optional feature (macro LOADER_CHECKSUM_EN): one checksum byte follows the
// image; it must equal the XOR of every preceding stream byte, otherwise the
// load ends in ERR with the CPU still in reset.
// -----------------------------------------------------------------------------
module inst_mem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  inst_mem_loader_if.slave     bus,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 err
);

  // Largest word count that fits in memory.
  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_FIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state;
  logic [7:0]            len_hi;
  logic [15:0]           num_words;
  logic [1:0]            byte_cnt;
  logic [23:0]           asm_q;      // first three bytes of the word in flight
  // One bit wider than the address so N = 2^ADDR_WIDTH does not wrap.
  logic [ADDR_WIDTH:0]   word_idx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic                  xfer;
  logic [15:0]           len_word;

  // Ready depends on the state register only, never on in_valid.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.in_ready = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA: bus.in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                     bus.in_ready = 1'b1;
`endif
      default:                    bus.in_ready = 1'b0;
    endcase
  end

  assign xfer     = bus.in_valid && bus.in_ready;
  assign len_word = {len_hi, bus.in_byte};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      len_hi        <= '0;
      num_words     <= '0;
      byte_cnt      <= '0;
      asm_q         <= '0;
      word_idx      <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_rst       <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;  // strobe lasts exactly one cycle

      case (state)
        S_IDLE: begin
          if (start) state <= S_LEN_HI;
        end

        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= bus.in_byte;
`ifdef LOADER_CHECKSUM_EN
            csum   <= csum ^ bus.in_byte;
`endif
            state  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (xfer) begin
            num_words <= len_word;
`ifdef LOADER_CHECKSUM_EN
            csum      <= csum ^ bus.in_byte;
`endif
            if (32'(len_word) > MAX_WORDS) begin
              err   <= 1'b1;
              state <= S_ERR;
            end else if (len_word == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_FIN;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= {asm_q[15:0], bus.in_byte};
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.in_byte;
`endif
            if (byte_cnt == 2'd3) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= word_idx[ADDR_WIDTH-1:0];
              bus.mem_wdata <= {asm_q, bus.in_byte};
              word_idx      <= word_idx + 1'b1;
              if (32'(word_idx) + 32'd1 == 32'(num_words)) begin
`ifdef LOADER_CHECKSUM_EN
                state <= S_CSUM;
`else
                state <= S_FIN;
`endif
              end
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            if (bus.in_byte == csum) begin
              state <= S_FIN;
            end else begin
              err   <= 1'b1;
              state <= S_ERR;
            end
          end
        end
`endif

        // The last write strobe occupies this cycle, so the CPU leaves reset
        // strictly after it.
        S_FIN: begin
          done    <= 1'b1;
          cpu_rst <= 1'b0;
          state   <= S_DONE;
        end

        S_DONE, S_ERR: begin
          if (start) begin
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_rst  <= 1'b1;
            byte_cnt <= '0;
            word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
            state    <= S_LEN_HI;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
